branch_trace_buffer: RTL and testbench
======================================

Name: branch_trace_buffer

Overview:
- Parametrised capture buffer for resolved branches in the EX stage. Sits beside the branch unit in cpu_top.
- Records selected branch events as {taken, pc, target, timestamp} entries in a first-word-fall-through (FWFT) FIFO.
- A bench or debug port drains the FIFO over a valid/ready handshake.
- Replaces ad-hoc per-cycle branch printing with a synthesizable trace of configurable depth, capture mode and full policy.

Parameters:
- ADDR_W, 32, width of branch PC and target.
- DEPTH, 16, FIFO entries; power of two, at least 2.
- TS_W, 16, timestamp counter width.
- OVF_W, 8, dropped-event counter width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- enable_i  in  1  capture enable; a 1->0 transition clears the freeze state.
- mode_i  in  2  capture mode: 00 off, 01 taken-only/drop-new, 10 all/drop-new, 11 taken-only/freeze-on-full.
- br_valid_i  in  1  branch resolved this cycle.
- br_taken_i  in  1  branch taken.
- br_pc_i  in  ADDR_W  PC of the branch.
- br_target_i  in  ADDR_W  computed target.
- rd_ready_i  in  1  consumer accepts the head entry.
- rd_valid_o  out  1  head entry valid.
- rd_taken_o  out  1  head entry taken flag.
- rd_pc_o  out  ADDR_W  head entry PC.
- rd_target_o  out  ADDR_W  head entry target.
- rd_stamp_o  out  TS_W  head entry timestamp.
- count_o  out  clog2(DEPTH)+1  current occupancy.
- full_o  out  1  count_o == DEPTH.
- frozen_o  out  1  capture halted by mode 11.
- ovf_cnt_o  out  OVF_W  qualifying events dropped.

Behaviour:
- Reset (synchronous, rst=1 at a clk edge): FIFO empty, count_o=0, rd_valid_o=0, all rd_* data=0, full_o=0, frozen_o=0, ovf_cnt_o=0, timestamp=0.
  - Reset mid-operation discards all entries with no partial pop.
- Timestamp: free-running TS_W counter.
  - 0 in the first cycle after reset; +1 every cycle; wraps from all ones to 0.
- Qualifying event: all of the following hold in the same cycle:
  - br_valid_i=1, enable_i=1, mode_i!=00, frozen_o=0;
  - br_taken_i=1 when mode_i is 01 or 11.
- Stored entry is the inputs in the event cycle plus the timestamp value of that same cycle.
- Push:
  - A qualifying event with FIFO not full is written at the clock edge.
  - It is visible on rd_valid_o/rd_* the next cycle if the FIFO was empty (one-cycle latency).
- Pop:
  - A handshake occurs when rd_valid_o=1 and rd_ready_i=1 at a clock edge; the head advances.
  - The next entry is presented the following cycle.
  - rd_ready_i with rd_valid_o=0 has no effect.
- Data stability: rd_* remain stable while rd_valid_o=1 and rd_ready_i=0.
- Simultaneous push and pop:
  - Both take effect; count_o is unchanged.
  - When full, the pop frees a slot and the push is accepted, so no drop and ovf_cnt_o is unchanged.
  - When empty, no pop occurs; the push lands and count_o becomes 1.
- Full without a pop:
  - Modes 01/10: the event is dropped; ovf_cnt_o increments, saturating at all ones.
  - Mode 11: the event is dropped, ovf_cnt_o increments, and frozen_o=1 from the next cycle.
    - While frozen, no events qualify and draining is still allowed.
    - frozen_o clears the cycle after enable_i is sampled 0, or on reset.
- Mode changes take effect the same cycle and do not touch stored entries. Mode 00 still allows draining.
- Pointers: clog2(DEPTH) bits, natural wrap. Distinguish full from empty via count_o.
- Storage: register array; all outputs registered, with no combinational path from br_* to rd_*.

Test Plan:
- Reset, then mode 01 and enable_i=1; pulse br_valid_i with taken=1, pc=0x10, target=0x40 at timestamp 5, rd_ready_i=0 -> next cycle rd_valid_o=1, rd_pc_o=0x10, rd_target_o=0x40, rd_stamp_o=5, count_o=1.
- Mode 01, one not-taken event then one taken event -> only the taken event is stored (count_o=1). Repeat in mode 10 -> count_o=2 and the first entry has rd_taken_o=0.
- DEPTH=16, mode 10, rd_ready_i=0, 18 events -> full_o=1, count_o=16, ovf_cnt_o=2. Then drain -> 16 entries in order with strictly increasing stamps.
- Full FIFO with a simultaneous event and rd_ready_i=1 -> count_o stays 16, ovf_cnt_o unchanged, and the new entry is the last one drained.
- Mode 11 fill to 16, then one more taken event -> frozen_o=1, ovf_cnt_o=1. Drain 1 entry and send another event -> not stored. Set enable_i=0 for one cycle, then 1 -> frozen_o=0 and the next event is stored.
- Assert rst with count_o=7 mid-drain -> next cycle rd_valid_o=0, count_o=0, ovf_cnt_o=0, stamp restarts at 0. Separately, TS_W=4 with events 20 cycles apart -> stamps wrap modulo 16.

Source files
------------

// File: rtl/branch_trace_buffer.sv
// Branch trace capture FIFO: records selected resolved branches with a timestamp
// and presents them first-word-fall-through on a registered valid/ready read port.
module branch_trace_buffer #(
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 16,
  parameter int TS_W   = 16,
  parameter int OVF_W  = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable_i,
  input  logic [1:0]               mode_i,
  input  logic                     br_valid_i,
  input  logic                     br_taken_i,
  input  logic [ADDR_W-1:0]        br_pc_i,
  input  logic [ADDR_W-1:0]        br_target_i,
  input  logic                     rd_ready_i,
  output logic                     rd_valid_o,
  output logic                     rd_taken_o,
  output logic [ADDR_W-1:0]        rd_pc_o,
  output logic [ADDR_W-1:0]        rd_target_o,
  output logic [TS_W-1:0]          rd_stamp_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     frozen_o,
  output logic [OVF_W-1:0]         ovf_cnt_o
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = 1 + 2 * ADDR_W + TS_W;

  // Handshake: an entry transfers when rd_valid_o and rd_ready_i are both high
  // at a rising clk edge; rd_* hold steady while rd_valid_o=1 and rd_ready_i=0.

  logic [ENT_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr, rd_ptr_nxt;
  logic [CNT_W-1:0] count_q, count_nxt, count_after_pop;
  logic [ENT_W-1:0] head_q, head_nxt, wr_entry;
  logic [TS_W-1:0]  ts_q;
  logic             rd_valid_q, full_q, frozen_q;
  logic [OVF_W-1:0] ovf_q;
  logic             qualify, pop, push, drop;

  always_comb begin
    qualify         = 1'b0;
    pop             = 1'b0;
    push            = 1'b0;
    drop            = 1'b0;
    wr_entry        = {br_taken_i, br_pc_i, br_target_i, ts_q};
    head_nxt        = head_q;
    qualify = br_valid_i && enable_i && (mode_i != 2'b00) && !frozen_q &&
              (br_taken_i || (mode_i == 2'b10));
    pop             = rd_valid_q && rd_ready_i;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    push            = qualify && (!full_q || pop);
    drop            = qualify && full_q && !pop;
    rd_ptr_nxt      = rd_ptr + PTR_W'(pop);
    count_after_pop = count_q - CNT_W'(pop);
    count_nxt       = count_after_pop + CNT_W'(push);
    if (count_after_pop == '0) begin
      if (push) head_nxt = wr_entry;
    end else begin
      head_nxt = mem[rd_ptr_nxt];
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_entry;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= '0;
      head_q     <= '0;
      ts_q       <= '0;
      rd_valid_q <= 1'b0;
      full_q     <= 1'b0;
      frozen_q   <= 1'b0;
      ovf_q      <= '0;
    end else begin
      ts_q       <= ts_q + TS_W'(1);
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      rd_ptr     <= rd_ptr_nxt;
      count_q    <= count_nxt;
      head_q     <= head_nxt;
      rd_valid_q <= (count_nxt != '0);
      full_q     <= (count_nxt == CNT_W'(DEPTH));
      if (drop && (ovf_q != '1)) ovf_q <= ovf_q + OVF_W'(1);
      // Freeze only arises from a qualifying event, which needs enable_i=1,
      // so the two branches below never compete.
      if (!enable_i) frozen_q <= 1'b0;
      else if (drop && (mode_i == 2'b11)) frozen_q <= 1'b1;
    end
  end

  assign {rd_taken_o, rd_pc_o, rd_target_o, rd_stamp_o} = head_q;
  assign rd_valid_o = rd_valid_q;
  assign count_o    = count_q;
  assign full_o     = full_q;
  assign frozen_o   = frozen_q;
  assign ovf_cnt_o  = ovf_q;
endmodule

// File: tb/tb_branch_trace_buffer.sv
// Directed bench for branch_trace_buffer: default instance plus a TS_W=4 /
// DEPTH=4 instance sharing the same stimulus for timestamp wrap checks.
module tb_branch_trace_buffer;
  localparam int W = 1 + 32 + 32 + 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable_i = 1'b0;
  logic [1:0]  mode_i = 2'b00;
  logic        br_valid_i = 1'b0;
  logic        br_taken_i = 1'b0;
  logic [31:0] br_pc_i = '0;
  logic [31:0] br_target_i = '0;
  logic        rd_ready_i = 1'b0;

  logic        rd_valid_o, rd_taken_o, full_o, frozen_o;
  logic [31:0] rd_pc_o, rd_target_o;
  logic [15:0] rd_stamp_o;
  logic [4:0]  count_o;
  logic [7:0]  ovf_cnt_o;

  logic        rd_valid_2, rd_taken_2, full_2, frozen_2;
  logic [31:0] rd_pc_2, rd_target_2;
  logic [3:0]  rd_stamp_2;
  logic [2:0]  count_2;
  logic [7:0]  ovf_cnt_2;

  logic [W-1:0] exp_q[$];
  int tb_ts = 0;
  int checks = 0;
  int errors = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  branch_trace_buffer #(.ADDR_W(32), .DEPTH(16), .TS_W(16), .OVF_W(8)) dut (
    .clk(clk), .rst(rst), .enable_i(enable_i), .mode_i(mode_i),
    .br_valid_i(br_valid_i), .br_taken_i(br_taken_i), .br_pc_i(br_pc_i),
    .br_target_i(br_target_i), .rd_ready_i(rd_ready_i),
    .rd_valid_o(rd_valid_o), .rd_taken_o(rd_taken_o), .rd_pc_o(rd_pc_o),
    .rd_target_o(rd_target_o), .rd_stamp_o(rd_stamp_o), .count_o(count_o),
    .full_o(full_o), .frozen_o(frozen_o), .ovf_cnt_o(ovf_cnt_o)
  );

  branch_trace_buffer #(.ADDR_W(32), .DEPTH(4), .TS_W(4), .OVF_W(8)) dut_ts4 (
    .clk(clk), .rst(rst), .enable_i(enable_i), .mode_i(mode_i),
    .br_valid_i(br_valid_i), .br_taken_i(br_taken_i), .br_pc_i(br_pc_i),
    .br_target_i(br_target_i), .rd_ready_i(rd_ready_i),
    .rd_valid_o(rd_valid_2), .rd_taken_o(rd_taken_2), .rd_pc_o(rd_pc_2),
    .rd_target_o(rd_target_2), .rd_stamp_o(rd_stamp_2), .count_o(count_2),
    .full_o(full_2), .frozen_o(frozen_2), .ovf_cnt_o(ovf_cnt_2)
  );

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
    tb_ts++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
    tb_ts = 0;
    exp_q.delete();
  endtask

  task automatic ev(input logic t, input logic [31:0] pc, input logic [31:0] tg,
                    input bit store);
    br_valid_i  = 1'b1;
    br_taken_i  = t;
    br_pc_i     = pc;
    br_target_i = tg;
    if (store) exp_q.push_back({t, pc, tg, tb_ts[15:0]});
    step();
    br_valid_i  = 1'b0;
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("check %s failed", tag);
    end
  endtask

  task automatic drain(input int n);
    logic [W-1:0] e;
    rd_ready_i = 1'b1;
    for (int i = 0; i < n; i++) begin
      if (exp_q.size() == 0) begin
        chk("drain_model_empty", 64'(exp_q.size()), 64'd1);
        break;
      end
      e = exp_q.pop_front();
      chk("drain_valid",  64'(rd_valid_o),  64'd1);
      chk("drain_taken",  64'(rd_taken_o),  64'(e[80]));
      chk("drain_pc",     64'(rd_pc_o),     64'(e[79:48]));
      chk("drain_target", 64'(rd_target_o), 64'(e[47:16]));
      chk("drain_stamp",  64'(rd_stamp_o),  64'(e[15:0]));
      step();
    end
    rd_ready_i = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    // reset state
    do_reset();
    chk("rst_valid", 64'(rd_valid_o), 64'd0);
    chk("rst_count", 64'(count_o), 64'd0);
    chk("rst_full", 64'(full_o), 64'd0);
    chk("rst_frozen", 64'(frozen_o), 64'd0);
    chk("rst_ovf", 64'(ovf_cnt_o), 64'd0);
    chk("rst_pc", 64'(rd_pc_o), 64'd0);
    chk("rst_stamp", 64'(rd_stamp_o), 64'd0);

    // single taken event at timestamp 5, one-cycle latency, stable while stalled
    mode_i = 2'b01;
    enable_i = 1'b1;
    while (tb_ts < 5) step();
    ev(1'b1, 32'h10, 32'h40, 1'b0);
    chk("t1_valid", 64'(rd_valid_o), 64'd1);
    chk("t1_pc", 64'(rd_pc_o), 64'h10);
    chk("t1_target", 64'(rd_target_o), 64'h40);
    chk("t1_stamp", 64'(rd_stamp_o), 64'd5);
    chk("t1_count", 64'(count_o), 64'd1);
    step();
    chk("t1_hold_pc", 64'(rd_pc_o), 64'h10);
    chk("t1_hold_stamp", 64'(rd_stamp_o), 64'd5);

    // mode 01 filters not-taken; mode 10 keeps both
    do_reset();
    mode_i = 2'b01;
    ev(1'b0, 32'h20, 32'h24, 1'b0);
    ev(1'b1, 32'h28, 32'h50, 1'b1);
    chk("t2a_count", 64'(count_o), 64'd1);
    drain(1);
    do_reset();
    mode_i = 2'b10;
    ev(1'b0, 32'h30, 32'h34, 1'b1);
    ev(1'b1, 32'h38, 32'h60, 1'b1);
    chk("t2b_count", 64'(count_o), 64'd2);
    chk("t2b_taken0", 64'(rd_taken_o), 64'd0);
    drain(2);
    chk("t2b_empty", 64'(rd_valid_o), 64'd0);

    // 18 events into 16 slots, drop-new
    do_reset();
    mode_i = 2'b10;
    for (int i = 0; i < 18; i++)
      ev(1'(i % 2), 32'h100 + 32'(4 * i), 32'h1100 + 32'(4 * i), i < 16);
    chk("t3_full", 64'(full_o), 64'd1);
    chk("t3_count", 64'(count_o), 64'd16);
    chk("t3_ovf", 64'(ovf_cnt_o), 64'd2);
    drain(16);
    chk("t3_empty", 64'(rd_valid_o), 64'd0);
    chk("t3_count0", 64'(count_o), 64'd0);

    // full + simultaneous push and pop: accepted, no drop
    do_reset();
    mode_i = 2'b10;
    for (int i = 0; i < 16; i++) ev(1'b1, 32'h200 + 32'(4 * i), 32'h300, 1'b1);
    chk("t4_head", 64'(rd_pc_o), 64'h200);
    void'(exp_q.pop_front());
    rd_ready_i = 1'b1;
    ev(1'b1, 32'hAAA, 32'hBBB, 1'b1);
    rd_ready_i = 1'b0;
    chk("t4_count", 64'(count_o), 64'd16);
    chk("t4_ovf", 64'(ovf_cnt_o), 64'd0);
    drain(16);

    // mode 11 freeze-on-full
    do_reset();
    mode_i = 2'b11;
    for (int i = 0; i < 16; i++) ev(1'b1, 32'h400 + 32'(4 * i), 32'h500, 1'b1);
    ev(1'b1, 32'h4F0, 32'h500, 1'b0);
    chk("t5_frozen", 64'(frozen_o), 64'd1);
    chk("t5_ovf", 64'(ovf_cnt_o), 64'd1);
    drain(1);
    ev(1'b1, 32'h999, 32'h500, 1'b0);
    chk("t5_blocked_count", 64'(count_o), 64'd15);
    chk("t5_blocked_ovf", 64'(ovf_cnt_o), 64'd1);
    chk("t5_still_frozen", 64'(frozen_o), 64'd1);
    enable_i = 1'b0;
    step();
    enable_i = 1'b1;
    chk("t5_unfrozen", 64'(frozen_o), 64'd0);
    ev(1'b1, 32'h777, 32'h500, 1'b1);
    chk("t5_count", 64'(count_o), 64'd16);
    drain(16);

    // reset mid-drain at count 7
    do_reset();
    mode_i = 2'b10;
    for (int i = 0; i < 10; i++) ev(1'b1, 32'h600 + 32'(4 * i), 32'h700, 1'b1);
    drain(3);
    chk("t6_count7", 64'(count_o), 64'd7);
    do_reset();
    chk("t6_valid", 64'(rd_valid_o), 64'd0);
    chk("t6_count", 64'(count_o), 64'd0);
    chk("t6_ovf", 64'(ovf_cnt_o), 64'd0);
    mode_i = 2'b10;
    ev(1'b1, 32'h5, 32'h6, 1'b1);
    chk("t6_stamp0", 64'(rd_stamp_o), 64'd0);
    drain(1);

    // TS_W=4 instance: events at cycles 10, 30, 50 -> stamps 10, 14, 2
    do_reset();
    mode_i = 2'b10;
    for (int k = 0; k < 3; k++) begin
      while (tb_ts < 10 + 20 * k) step();
      ev(1'b1, 32'h800 + 32'(k), 32'h900, 1'b0);
      chk("t7_valid", 64'(rd_valid_2), 64'd1);
      case (k)
        0: chk("t7_stamp_a", 64'(rd_stamp_2), 64'd10);
        1: chk("t7_stamp_b", 64'(rd_stamp_2), 64'd14);
        default: chk("t7_stamp_c", 64'(rd_stamp_2), 64'd2);
      endcase
      rd_ready_i = 1'b1;
      step();
      rd_ready_i = 1'b0;
      chk("t7_empty", 64'(count_2), 64'd0);
    end

    // ---------------- final report ----------------
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
